dmi_arbiter: RTL and testbench
==============================

Name: dmi_arbiter

Overview:
Shares the single DMI port of the Debug Module between N_REQ DMI masters, for example the JTAG DTM and a second debug transport. Arbitration is round-robin with a locked grant: one transaction is outstanding downstream at a time. The block latches the winner's request, drives the DM-side valid/ready handshake and routes the response back to the winner only. A timeout returns FAILED if the Debug Module never answers.

Parameters:
N_REQ, 2, number of upstream DMI masters (2..8)
TIMEOUT_CYCLES, 255, BUSY cycles without dmi_req_ready before abort; 0 disables timeout
TO_W, 8, timeout counter width; must satisfy 2**TO_W > TIMEOUT_CYCLES

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
up_valid  in  N_REQ  per-master request valid; held until that master's up_ready pulse
up_addr  in  N_REQ*DMI_ADDR_WIDTH  packed addresses; master i occupies slice i
up_wdata  in  N_REQ*DMI_DATA_WIDTH  packed write data
up_op  in  N_REQ*2  packed dmi_op_e
up_ready  out  N_REQ  one-hot, one-cycle completion pulse
up_rdata  out  DMI_DATA_WIDTH  response data; valid while any up_ready bit is set
up_resp  out  2  response code; valid while any up_ready bit is set
dmi_addr  out  DMI_ADDR_WIDTH  request address to the DM
dmi_wdata  out  DMI_DATA_WIDTH  request write data to the DM
dmi_op  out  2  request op to the DM
dmi_req_valid  out  1  DM request valid
dmi_req_ready  in  1  DM completion; dmi_rdata and dmi_resp are sampled in the same cycle
dmi_rdata  in  DMI_DATA_WIDTH  DM read data
dmi_resp  in  2  DM response
grant_id  out  $clog2(N_REQ)  index of the current or last granted master
timeout_pulse  out  1  one-cycle pulse when a transaction is aborted by timeout

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: all outputs 0; state IDLE; round-robin pointer 0; timeout counter 0.
- Reset mid-transaction: the in-flight DM transaction is abandoned; no up_ready pulse is issued.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If any up_valid bit is set, pick the winner: the first set bit at or after the pointer, searching upward and wrapping modulo N_REQ.
  - Latch the winner's addr, wdata and op into dmi_addr, dmi_wdata and dmi_op. Set grant_id to the winner.
  - Winner's op == DMI_OP_NOP: go to DONE with resp SUCCESS and rdata 0. No downstream request is made.
  - Otherwise: go to BUSY and set dmi_req_valid = 1 at the next edge.
- BUSY:
  - dmi_req_valid is held at 1; dmi_addr, dmi_wdata and dmi_op are stable.
  - The timeout counter increments each cycle.
  - dmi_req_ready = 1: register dmi_rdata and dmi_resp, clear dmi_req_valid, go to DONE.
  - Else, if TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES: resp = DMI_RESP_FAILED, rdata = 0, pulse timeout_pulse, clear dmi_req_valid, go to DONE.
  - dmi_req_ready takes priority over timeout in the same cycle.
- DONE:
  - up_ready[grant_id] = 1 for exactly one cycle, with the registered up_rdata and up_resp.
  - Pointer becomes (grant_id + 1) mod N_REQ; counter clears; go to IDLE.
- IDLE after DONE: the completed master's valid is still visible on the DONE edge. The master clears it on up_ready, so IDLE evaluates fresh requests and no double issue occurs.
- Latency: up_valid seen in cycle 0 -> dmi_req_valid in cycle 1 -> DM ready in cycle k (k >= 1) -> up_ready in cycle k+1. The minimum round trip is 2 cycles. A NOP completes with up_ready in cycle 1.
- Grant lock: no re-arbitration while in BUSY or DONE. Requests from other masters wait and are not lost.
- Withdrawal: up_valid dropping after grant is ignored; the latched request completes.
- Fairness: with all masters continuously requesting, each is served once per N_REQ transactions.
- up_rdata and up_resp hold their last value outside DONE.

Decomposition:
- jtag_dmi_pkg (existing) supplies DMI_ADDR_WIDTH, DMI_DATA_WIDTH, dmi_op_e and dmi_resp_e.
- Add to jtag_dmi_pkg: typedef enum dmi_arb_state_e {ARB_IDLE, ARB_BUSY, ARB_DONE}, and DMI_RESP_FAILED = 2'd2 if it is not already present.
- Sub-module dmi_rr_picker: combinational round-robin priority picker. Inputs: req vector and pointer. Outputs: any and winner index. It is reused by future bus arbiters.

Test Plan:
1. Single master 0 read: up_valid=01, addr 7'h11, op READ. DM sets ready one cycle after dmi_req_valid with rdata 32'hCAFE_0001, resp 0. Required: dmi_addr=7'h11 held while valid; up_ready=01 exactly one cycle; up_rdata=32'hCAFE_0001; up_resp=0; total latency 3 cycles.
2. Contention: both masters request continuously (write op) and the DM responds immediately. Required: grant order 0,1,0,1; no up_ready for the ungranted master; each master's wdata reaches dmi_wdata unaltered.
3. Timeout: TIMEOUT_CYCLES=4, dmi_req_ready tied low. Required: dmi_req_valid high for exactly 4 cycles; timeout_pulse once; up_resp=2; up_rdata=0; the arbiter then serves the next request.
4. Ready on the timeout cycle: the DM asserts ready in the same cycle the counter reaches the limit, with resp 0. Required: success is returned and there is no timeout_pulse.
5. NOP: master 1 requests op NOP. Required: dmi_req_valid stays 0; up_ready=10 one cycle later; up_resp=0.
6. Reset mid-BUSY: rst asserted for 1 cycle while dmi_req_valid=1. Required: next cycle all outputs 0 and no up_ready pulse; after reset, a fresh request from master 1 is granted first when master 0 is idle.

Source files
------------

// File: rtl/jtag_dmi_pkg.sv
// Shared DMI types: widths, op/response codes and the arbiter FSM state.
package jtag_dmi_pkg;

    localparam int unsigned DMI_ADDR_WIDTH = 7;
    localparam int unsigned DMI_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        DMI_OP_NOP   = 2'd0,
        DMI_OP_READ  = 2'd1,
        DMI_OP_WRITE = 2'd2,
        DMI_OP_RSVD  = 2'd3
    } dmi_op_e;

    typedef enum logic [1:0] {
        DMI_RESP_SUCCESS = 2'd0,
        DMI_RESP_RSVD    = 2'd1,
        DMI_RESP_FAILED  = 2'd2,
        DMI_RESP_BUSY    = 2'd3
    } dmi_resp_e;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY,
        ARB_DONE
    } dmi_arb_state_e;

endpackage

// File: rtl/dmi_arbiter_if.sv
// Upstream request/response bundle plus the single DM-side DMI port.
interface dmi_arbiter_if
    import jtag_dmi_pkg::*;
#(
    parameter int unsigned N_REQ = 2
) ();

    localparam int unsigned ID_W = $clog2(N_REQ);

    // Upstream masters, packed with master i in slice i
    logic [N_REQ-1:0]                up_valid;
    logic [N_REQ*DMI_ADDR_WIDTH-1:0] up_addr;
    logic [N_REQ*DMI_DATA_WIDTH-1:0] up_wdata;
    logic [N_REQ*2-1:0]              up_op;
    logic [N_REQ-1:0]                up_ready;
    logic [DMI_DATA_WIDTH-1:0]       up_rdata;
    logic [1:0]                      up_resp;

    // Debug Module side
    logic [DMI_ADDR_WIDTH-1:0]       dmi_addr;
    logic [DMI_DATA_WIDTH-1:0]       dmi_wdata;
    logic [1:0]                      dmi_op;
    logic                            dmi_req_valid;
    logic                            dmi_req_ready;
    logic [DMI_DATA_WIDTH-1:0]       dmi_rdata;
    logic [1:0]                      dmi_resp;

    // Status
    logic [ID_W-1:0]                 grant_id;
    logic                            timeout_pulse;

    // Arbiter side
    modport master (
        input  up_valid, up_addr, up_wdata, up_op, dmi_req_ready, dmi_rdata, dmi_resp,
        output up_ready, up_rdata, up_resp, dmi_addr, dmi_wdata, dmi_op, dmi_req_valid,
               grant_id, timeout_pulse
    );

    // Environment side (upstream masters and the DM)
    modport slave (
        output up_valid, up_addr, up_wdata, up_op, dmi_req_ready, dmi_rdata, dmi_resp,
        input  up_ready, up_rdata, up_resp, dmi_addr, dmi_wdata, dmi_op, dmi_req_valid,
               grant_id, timeout_pulse
    );

endinterface

// File: rtl/dmi_rr_picker.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module dmi_rr_picker #(
    parameter int unsigned N_REQ = 2,
    localparam int unsigned W    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [W-1:0]     ptr_i,
    output logic             any_o,
    output logic [W-1:0]     winner_o
);

    // Scan upward from the pointer; the first hit wins
    always_comb begin
        logic        found;
        int unsigned idx;
        found    = 1'b0;
        idx      = 0;
        winner_o = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = (32'(ptr_i) + i) % N_REQ;
            if (req_i[W'(idx)] && !found) begin
                found    = 1'b1;
                winner_o = W'(idx);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/dmi_arbiter.sv
// Round-robin arbiter sharing one DM DMI port between N_REQ masters, one transaction
// outstanding at a time, with an optional BUSY timeout that returns FAILED.
module dmi_arbiter
    import jtag_dmi_pkg::*;
#(
    parameter int unsigned N_REQ          = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TO_W           = 8
) (
    input  logic          clk,
    input  logic          rst,
    dmi_arbiter_if.master bus
);

    localparam int unsigned ID_W = $clog2(N_REQ);

    dmi_arb_state_e            state_q, state_d;
    logic [ID_W-1:0]           ptr_q, ptr_d;
    logic [ID_W-1:0]           grant_q, grant_d;
    logic [TO_W-1:0]           cnt_q, cnt_d;
    logic [DMI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DMI_DATA_WIDTH-1:0] wdata_q, wdata_d;
    dmi_op_e                   op_q, op_d;
    logic                      req_valid_q, req_valid_d;
    logic [DMI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]                resp_q, resp_d;
    logic                      to_pulse_q, to_pulse_d;

    logic                      pick_any;
    logic [ID_W-1:0]           pick_idx;
    logic [N_REQ-1:0]          up_ready;

    dmi_rr_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .req_i    (bus.up_valid),
        .ptr_i    (ptr_q),
        .any_o    (pick_any),
        .winner_o (pick_idx)
    );

    // Next-state: arbitrate in IDLE, wait/timeout in BUSY, hand back in DONE
    always_comb begin
        logic [TO_W-1:0] cnt_inc;
        dmi_op_e         win_op;
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        op_d        = op_q;
        req_valid_d = req_valid_q;
        rdata_d     = rdata_q;
        resp_d      = resp_q;
        to_pulse_d  = 1'b0;
        cnt_inc     = cnt_q + TO_W'(1);
        win_op      = dmi_op_e'(bus.up_op[32'(pick_idx)*2 +: 2]);

        unique case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    addr_d  = bus.up_addr[32'(pick_idx)*DMI_ADDR_WIDTH +: DMI_ADDR_WIDTH];
                    wdata_d = bus.up_wdata[32'(pick_idx)*DMI_DATA_WIDTH +: DMI_DATA_WIDTH];
                    op_d    = win_op;
                    if (win_op == DMI_OP_NOP) begin
                        // NOP never touches the DM; complete locally
                        rdata_d = '0;
                        resp_d  = DMI_RESP_SUCCESS;
                        state_d = ARB_DONE;
                    end else begin
                        req_valid_d = 1'b1;
                        state_d     = ARB_BUSY;
                    end
                end
            end
            ARB_BUSY: begin
                cnt_d = cnt_inc;
                // A DM answer wins over a timeout landing in the same cycle
                if (bus.dmi_req_ready) begin
                    rdata_d     = bus.dmi_rdata;
                    resp_d      = bus.dmi_resp;
                    req_valid_d = 1'b0;
                    state_d     = ARB_DONE;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_inc == TO_W'(TIMEOUT_CYCLES))) begin
                    rdata_d     = '0;
                    resp_d      = DMI_RESP_FAILED;
                    to_pulse_d  = 1'b1;
                    req_valid_d = 1'b0;
                    state_d     = ARB_DONE;
                end
            end
            ARB_DONE: begin
                ptr_d   = (grant_q == ID_W'(N_REQ - 1)) ? '0 : grant_q + ID_W'(1);
                cnt_d   = '0;
                state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            op_q        <= DMI_OP_NOP;
            req_valid_q <= 1'b0;
            rdata_q     <= '0;
            resp_q      <= '0;
            to_pulse_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            op_q        <= op_d;
            req_valid_q <= req_valid_d;
            rdata_q     <= rdata_d;
            resp_q      <= resp_d;
            to_pulse_q  <= to_pulse_d;
        end
    end

    // Completion strobe to the granted master only
    always_comb begin
        up_ready = '0;
        if (state_q == ARB_DONE) begin
            up_ready[grant_q] = 1'b1;
        end
    end

    assign bus.up_ready      = up_ready;
    assign bus.up_rdata      = rdata_q;
    assign bus.up_resp       = resp_q;
    assign bus.dmi_addr      = addr_q;
    assign bus.dmi_wdata     = wdata_q;
    assign bus.dmi_op        = op_q;
    assign bus.dmi_req_valid = req_valid_q;
    assign bus.grant_id      = grant_q;
    assign bus.timeout_pulse = to_pulse_q;

endmodule

// File: tb/tb_dmi_arbiter.sv
// Directed bench for dmi_arbiter with two masters and a 4-cycle timeout.
module tb_dmi_arbiter;
    import jtag_dmi_pkg::*;

    logic clk;
    logic rst;
    logic dm_auto;
    logic dm_ready;
    int   n_cmp;
    int   n_err;

    dmi_arbiter_if #(.N_REQ(2)) bus ();

    dmi_arbiter #(
        .N_REQ          (2),
        .TIMEOUT_CYCLES (4),
        .TO_W           (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // DM model: either answers in the same cycle as valid, or is driven by hand
    assign bus.dmi_req_ready = dm_auto ? bus.dmi_req_valid : dm_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int m, input logic [6:0] a, input logic [31:0] d,
                           input logic [1:0] op);
        bus.up_addr[m*7 +: 7]    = a;
        bus.up_wdata[m*32 +: 32] = d;
        bus.up_op[m*2 +: 2]      = op;
        bus.up_valid[m]          = 1'b1;
    endtask

    initial begin
        logic [31:0] wd [2];
        n_cmp = 0;
        n_err = 0;
        dm_auto = 1'b0;
        dm_ready = 1'b0;
        rst = 1'b1;
        bus.up_valid = '0;
        bus.up_addr = '0;
        bus.up_wdata = '0;
        bus.up_op = '0;
        bus.dmi_rdata = '0;
        bus.dmi_resp = '0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        check_eq("rst_up_ready", 64'(bus.up_ready), 64'h0);
        check_eq("rst_req_valid", 64'(bus.dmi_req_valid), 64'h0);
        check_eq("rst_grant", 64'(bus.grant_id), 64'h0);
        check_eq("rst_addr", 64'(bus.dmi_addr), 64'h0);
        check_eq("rst_timeout", 64'(bus.timeout_pulse), 64'h0);

        // T1: master 0 read, DM answers one cycle after valid
        set_req(0, 7'h11, 32'h0, 2'd1);
        tick();
        check_eq("t1_c1_valid", 64'(bus.dmi_req_valid), 64'h1);
        check_eq("t1_c1_addr", 64'(bus.dmi_addr), 64'h11);
        check_eq("t1_c1_op", 64'(bus.dmi_op), 64'h1);
        check_eq("t1_c1_up_ready", 64'(bus.up_ready), 64'h0);
        tick();
        check_eq("t1_c2_valid", 64'(bus.dmi_req_valid), 64'h1);
        check_eq("t1_c2_addr", 64'(bus.dmi_addr), 64'h11);
        check_eq("t1_c2_up_ready", 64'(bus.up_ready), 64'h0);
        dm_ready = 1'b1;
        bus.dmi_rdata = 32'hCAFE_0001;
        bus.dmi_resp = 2'd0;
        tick();
        dm_ready = 1'b0;
        check_eq("t1_c3_up_ready", 64'(bus.up_ready), 64'h1);
        check_eq("t1_c3_rdata", 64'(bus.up_rdata), 64'hCAFE_0001);
        check_eq("t1_c3_resp", 64'(bus.up_resp), 64'h0);
        check_eq("t1_c3_valid", 64'(bus.dmi_req_valid), 64'h0);
        bus.up_valid = '0;
        tick();
        check_eq("t1_c4_up_ready", 64'(bus.up_ready), 64'h0);
        check_eq("t1_c4_rdata_hold", 64'(bus.up_rdata), 64'hCAFE_0001);

        // T5: master 1 NOP completes locally, pointer moves back to 0
        set_req(1, 7'h12, 32'h0, 2'd0);
        tick();
        check_eq("t5_up_ready", 64'(bus.up_ready), 64'h2);
        check_eq("t5_resp", 64'(bus.up_resp), 64'h0);
        check_eq("t5_rdata", 64'(bus.up_rdata), 64'h0);
        check_eq("t5_req_valid", 64'(bus.dmi_req_valid), 64'h0);
        check_eq("t5_grant", 64'(bus.grant_id), 64'h1);
        bus.up_valid = '0;
        tick();
        check_eq("t5_up_ready_off", 64'(bus.up_ready), 64'h0);
        check_eq("t5_req_valid_off", 64'(bus.dmi_req_valid), 64'h0);

        // T2: both masters write continuously, DM answers immediately
        wd[0] = 32'h1111_0000;
        wd[1] = 32'h2222_0001;
        dm_auto = 1'b1;
        bus.dmi_rdata = 32'h0;
        set_req(0, 7'h20, wd[0], 2'd2);
        set_req(1, 7'h21, wd[1], 2'd2);
        for (int t = 0; t < 4; t++) begin
            tick();
            check_eq($sformatf("t2_%0d_grant", t), 64'(bus.grant_id), 64'(t % 2));
            check_eq($sformatf("t2_%0d_wdata", t), 64'(bus.dmi_wdata), 64'(wd[t % 2]));
            check_eq($sformatf("t2_%0d_valid", t), 64'(bus.dmi_req_valid), 64'h1);
            check_eq($sformatf("t2_%0d_op", t), 64'(bus.dmi_op), 64'h2);
            tick();
            check_eq($sformatf("t2_%0d_up_ready", t), 64'(bus.up_ready), 64'(1 << (t % 2)));
            tick();
            if (t == 3) bus.up_valid = '0;
            check_eq($sformatf("t2_%0d_idle", t), 64'(bus.up_ready), 64'h0);
        end
        dm_auto = 1'b0;

        // T3: DM never answers; abort after 4 BUSY cycles
        bus.dmi_rdata = 32'hDEAD_BEEF;
        set_req(0, 7'h22, 32'h0, 2'd1);
        for (int c = 1; c <= 4; c++) begin
            tick();
            check_eq($sformatf("t3_c%0d_valid", c), 64'(bus.dmi_req_valid), 64'h1);
            check_eq($sformatf("t3_c%0d_tmo", c), 64'(bus.timeout_pulse), 64'h0);
        end
        tick();
        check_eq("t3_valid_drop", 64'(bus.dmi_req_valid), 64'h0);
        check_eq("t3_tmo_pulse", 64'(bus.timeout_pulse), 64'h1);
        check_eq("t3_up_ready", 64'(bus.up_ready), 64'h1);
        check_eq("t3_resp", 64'(bus.up_resp), 64'h2);
        check_eq("t3_rdata", 64'(bus.up_rdata), 64'h0);
        bus.up_valid = '0;
        tick();
        check_eq("t3_tmo_once", 64'(bus.timeout_pulse), 64'h0);
        check_eq("t3_up_ready_off", 64'(bus.up_ready), 64'h0);

        // T4: ready arrives on the cycle the counter hits the limit
        set_req(1, 7'h33, 32'h0, 2'd1);
        for (int c = 1; c <= 3; c++) tick();
        tick();
        check_eq("t4_c4_valid", 64'(bus.dmi_req_valid), 64'h1);
        dm_ready = 1'b1;
        bus.dmi_rdata = 32'h1234_5678;
        bus.dmi_resp = 2'd0;
        tick();
        dm_ready = 1'b0;
        check_eq("t4_up_ready", 64'(bus.up_ready), 64'h2);
        check_eq("t4_resp", 64'(bus.up_resp), 64'h0);
        check_eq("t4_rdata", 64'(bus.up_rdata), 64'h1234_5678);
        check_eq("t4_no_tmo", 64'(bus.timeout_pulse), 64'h0);
        bus.up_valid = '0;
        tick();

        // T6: reset while BUSY abandons the transaction
        set_req(0, 7'h44, 32'hABCD_0044, 2'd2);
        tick();
        check_eq("t6_busy_valid", 64'(bus.dmi_req_valid), 64'h1);
        rst = 1'b1;
        bus.up_valid = '0;
        tick();
        rst = 1'b0;
        check_eq("t6_rst_valid", 64'(bus.dmi_req_valid), 64'h0);
        check_eq("t6_rst_addr", 64'(bus.dmi_addr), 64'h0);
        check_eq("t6_rst_wdata", 64'(bus.dmi_wdata), 64'h0);
        check_eq("t6_rst_op", 64'(bus.dmi_op), 64'h0);
        check_eq("t6_rst_up_ready", 64'(bus.up_ready), 64'h0);
        check_eq("t6_rst_rdata", 64'(bus.up_rdata), 64'h0);
        check_eq("t6_rst_resp", 64'(bus.up_resp), 64'h0);
        check_eq("t6_rst_grant", 64'(bus.grant_id), 64'h0);
        check_eq("t6_rst_tmo", 64'(bus.timeout_pulse), 64'h0);
        for (int c = 0; c < 2; c++) begin
            tick();
            check_eq($sformatf("t6_quiet%0d_ready", c), 64'(bus.up_ready), 64'h0);
            check_eq($sformatf("t6_quiet%0d_valid", c), 64'(bus.dmi_req_valid), 64'h0);
        end
        set_req(1, 7'h55, 32'h0, 2'd1);
        tick();
        check_eq("t6_m1_grant", 64'(bus.grant_id), 64'h1);
        check_eq("t6_m1_addr", 64'(bus.dmi_addr), 64'h55);
        check_eq("t6_m1_valid", 64'(bus.dmi_req_valid), 64'h1);
        dm_ready = 1'b1;
        bus.dmi_rdata = 32'hA5A5_0055;
        tick();
        dm_ready = 1'b0;
        check_eq("t6_m1_up_ready", 64'(bus.up_ready), 64'h2);
        check_eq("t6_m1_rdata", 64'(bus.up_rdata), 64'hA5A5_0055);
        bus.up_valid = '0;
        tick();
        check_eq("t6_m1_ready_off", 64'(bus.up_ready), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
